sort_unpermute: RTL

- Inverse of the sort stage: restores original input order after data has been sorted.
- Accepts a serial stream of sorted words, each tagged with its original array index. Writes each word into a local N-entry buffer at its tag position.
- Once all N slots are filled, streams the buffer out in original-index order.
- Sits downstream of the sorter, on the return path to consumers that need the original positions.

---
 rtl/sort_unpermute.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sort_unpermute.sv
// sort_unpermute: restores original array order after a sort stage.
//
// Sorted words arrive one per input handshake, each tagged with its original
// index. Every word is written into a local buffer at its tag position. Once all
// N slots hold a word, the buffer is streamed out in index order 0..N-1. Input
// and output phases never overlap.
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   in_valid/in_ready            input handshake
//   in_data, in_tag, in_last     sorted word, its original index, end-of-frame mark
//   out_valid/out_ready          output handshake
//   out_data, out_idx, out_last  word in original order, its index, final word
//   err_dup, err_range           one-cycle pulses: a beat was dropped
//   err_short                    one-cycle pulse: frame ended early and was discarded
module sort_unpermute #(
  parameter int N     = 6,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [IDXW-1:0]  in_tag,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             err_dup,
  output logic             err_range,
  output logic             err_short
);

  // Storage spans the full tag space so any tag value indexes safely; slots at
  // or above N are never written because such tags are rejected first.
  localparam int DEPTH = 1 << IDXW;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [IDXW:0]   N_EXT    = (IDXW + 1)'(N);

  typedef enum logic {COLLECT, EMIT} state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] fill_q, fill_d;
  logic [IDXW-1:0]  rd_idx_q, rd_idx_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             err_dup_q, err_dup_d;
  logic             err_range_q, err_range_d;
  logic             err_short_q, err_short_d;

  logic accept;
  logic tag_range_bad;
  logic tag_dup;
  logic frame_full;

  always_comb begin
    in_ready      = (state_q == COLLECT) && !rst;
    accept        = in_valid && in_ready;
    tag_range_bad = ({1'b0, in_tag} >= N_EXT);
    tag_dup       = !tag_range_bad && fill_q[in_tag];
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    rd_idx_d    = rd_idx_q;
    mem_d       = mem_q;
    err_dup_d   = 1'b0;
    err_range_d = 1'b0;
    err_short_d = 1'b0;
    frame_full  = 1'b0;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          err_range_d = tag_range_bad;
          err_dup_d   = tag_dup;
          if (!tag_range_bad && !tag_dup) begin
            mem_d[in_tag]  = in_data;
            fill_d[in_tag] = 1'b1;
          end
          // Fullness includes the current beat, so a completing beat wins over
          // in_last; a dropped beat carrying in_last still discards the frame.
          frame_full = &fill_d[N-1:0];
          if (frame_full) begin
            state_d = EMIT;
          end else if (in_last) begin
            err_short_d = 1'b1;
            fill_d      = '0;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            fill_d   = '0;
            state_d  = COLLECT;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      fill_q      <= '0;
      rd_idx_q    <= '0;
      err_dup_q   <= 1'b0;
      err_range_q <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      rd_idx_q    <= rd_idx_d;
      err_dup_q   <= err_dup_d;
      err_range_q <= err_range_d;
      err_short_q <= err_short_d;
    end
  end

  // Buffer contents carry no reset; the fill bitmap alone decides validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    out_valid = (state_q == EMIT);
    out_data  = out_valid ? mem_q[rd_idx_q] : '0;
    out_idx   = out_valid ? rd_idx_q : '0;
    out_last  = out_valid && (rd_idx_q == LAST_IDX);
    err_dup   = err_dup_q;
    err_range = err_range_q;
    err_short = err_short_q;
  end

endmodule
